// File: rtl/press_classifier_if.sv
// Button event bus between the debouncer side and the press classifier.
// The master drives the debounced level and press pulse. The slave
// returns the classified event pulses and the busy flag.
`timescale 1ns/1ps

interface press_classifier_if;
    logic db_level;
    logic db_tick;
    logic short_tick;
    logic long_tick;
    logic double_tick;
    logic repeat_tick;
    logic busy;

    modport master (
        output db_level,
        output db_tick,
        input  short_tick,
        input  long_tick,
        input  double_tick,
        input  repeat_tick,
        input  busy
    );

    modport slave (
        input  db_level,
        input  db_tick,
        output short_tick,
        output long_tick,
        output double_tick,
        output repeat_tick,
        output busy
    );
endinterface

// File: rtl/press_classifier.sv
// Press classifier: turns a debounced button stream into short, long,
// double and auto-repeat events. One shared duration counter is cleared on
// every state change. Every event output is a registered one-clock pulse.
`timescale 1ns/1ps

module press_classifier #(
    parameter int CNT_W         = 26,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DOUBLE_CYCLES = 15_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    press_classifier_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HELD      = 3'd1,
        LONG_HELD = 3'd2,
        GAP       = 3'd3,
        HELD2     = 3'd4
    } state_t;

    // Last counter value before each threshold fires. A transition on the
    // edge that sees this value puts the event pulse exactly N clocks after
    // the counter was cleared.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             lvl_r;
    logic             release_s;

    // Saturating increment. HELD2 has no upper bound on hold time, so the
    // counter must never wrap around to a small value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // A release is a falling edge of the debounced level against its registered copy.
    assign release_s = lvl_r & ~bus.db_level;

    // Register the debounced level to detect the release edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_r <= 1'b0;
        end else begin
            lvl_r <= bus.db_level;
        end
    end

    // Classification FSM with shared duration counter and registered pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            cnt_r           <= CNT_ZERO;
            bus.short_tick  <= 1'b0;
            bus.long_tick   <= 1'b0;
            bus.double_tick <= 1'b0;
            bus.repeat_tick <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            // Pulses default low so each one lasts exactly one clock.
            bus.short_tick  <= 1'b0;
            bus.long_tick   <= 1'b0;
            bus.double_tick <= 1'b0;
            bus.repeat_tick <= 1'b0;

            case (state_r)
                IDLE: begin
                    // The counter is parked at zero while idle. That keeps it
                    // from wrapping during long idle periods.
                    cnt_r <= CNT_ZERO;
                    if (bus.db_tick) begin
                        state_r  <= HELD;
                        bus.busy <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end

                HELD: begin
                    bus.busy <= 1'b1;
                    if (release_s) begin
                        // A release wins over the long threshold on the same edge.
                        state_r <= GAP;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == LONG_LAST) begin
                        state_r       <= LONG_HELD;
                        cnt_r         <= CNT_ZERO;
                        bus.long_tick <= 1'b1;
                    end else begin
                        state_r <= HELD;
                        cnt_r   <= sat_inc(cnt_r);
                    end
                end

                LONG_HELD: begin
                    if (release_s) begin
                        // A release ends the hold silently, even on a repeat point.
                        state_r  <= IDLE;
                        cnt_r    <= CNT_ZERO;
                        bus.busy <= 1'b0;
                    end else if (cnt_r == REPEAT_LAST) begin
                        state_r         <= LONG_HELD;
                        cnt_r           <= CNT_ZERO;
                        bus.repeat_tick <= 1'b1;
                        bus.busy        <= 1'b1;
                    end else begin
                        state_r  <= LONG_HELD;
                        cnt_r    <= sat_inc(cnt_r);
                        bus.busy <= 1'b1;
                    end
                end

                GAP: begin
                    if (bus.db_tick) begin
                        // A second press inside the window, including its last
                        // clock, makes this a double press.
                        state_r  <= HELD2;
                        cnt_r    <= CNT_ZERO;
                        bus.busy <= 1'b1;
                    end else if (cnt_r == DOUBLE_LAST) begin
                        state_r        <= IDLE;
                        cnt_r          <= CNT_ZERO;
                        bus.short_tick <= 1'b1;
                        bus.busy       <= 1'b0;
                    end else begin
                        state_r  <= GAP;
                        cnt_r    <= sat_inc(cnt_r);
                        bus.busy <= 1'b1;
                    end
                end

                HELD2: begin
                    // There is no long or repeat detection on the second press.
                    if (release_s) begin
                        state_r         <= IDLE;
                        cnt_r           <= CNT_ZERO;
                        bus.double_tick <= 1'b1;
                        bus.busy        <= 1'b0;
                    end else begin
                        state_r  <= HELD2;
                        cnt_r    <= sat_inc(cnt_r);
                        bus.busy <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encodings recover to idle without emitting an event.
                    state_r  <= IDLE;
                    cnt_r    <= CNT_ZERO;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Directed testbench for press_classifier using LONG=100, DOUBLE=50,
// REPEAT=20 and CNT_W=8. Expected event times are counted in clock edges
// from the edge that samples the first db_tick (t0).
`timescale 1ns/1ps

module tb_press_classifier;

    logic clk;
    logic reset;

    press_classifier_if bus ();

    press_classifier #(
        .CNT_W         (8),
        .LONG_CYCLES   (100),
        .DOUBLE_CYCLES (50),
        .REPEAT_CYCLES (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int test_count = 0;
    int fail_count = 0;
    int cyc = 0;
    int t0 = 0;

    int short_cnt = 0, long_cnt = 0, double_cnt = 0, repeat_cnt = 0, multi_cnt = 0;
    int short_last = 0, short_prev = 0, long_last = 0, double_last = 0;
    int repeat_last = 0, repeat_prev = 0;
    int short_base = 0, long_base = 0, double_base = 0, repeat_base = 0;
    int mon_n;

    initial clk = 1'b0;
    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Edge counter used to timestamp events.
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: samples 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        mon_n = int'(bus.short_tick) + int'(bus.long_tick) + int'(bus.double_tick) + int'(bus.repeat_tick);
        if (mon_n > 1) multi_cnt++;
        if (bus.short_tick === 1'b1) begin
            short_cnt++;
            short_prev = short_last;
            short_last = cyc;
        end
        if (bus.long_tick === 1'b1) begin
            long_cnt++;
            long_last = cyc;
        end
        if (bus.double_tick === 1'b1) begin
            double_cnt++;
            double_last = cyc;
        end
        if (bus.repeat_tick === 1'b1) begin
            repeat_cnt++;
            repeat_prev = repeat_last;
            repeat_last = cyc;
        end
    end

    // Watchdog: stop a run that fails to finish.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        short_base  = short_cnt;
        long_base   = long_cnt;
        double_base = double_cnt;
        repeat_base = repeat_cnt;
    endtask

    // db_tick for one edge (E0). t0 is the cycle stamp that edge will receive.
    task automatic start_press();
        @(negedge clk);
        bus.db_level = 1'b0;
        bus.db_tick  = 1'b1;
        t0 = cyc + 1;
        snap();
    endtask

    task automatic retick();
        @(negedge clk);
        bus.db_level = 1'b0;
        bus.db_tick  = 1'b1;
    endtask

    task automatic hold(input logic lv, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.db_level = lv;
            bus.db_tick  = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_short"},  {31'd0, bus.short_tick},  32'd0);
        check({tag, "_long"},   {31'd0, bus.long_tick},   32'd0);
        check({tag, "_double"}, {31'd0, bus.double_tick}, 32'd0);
        check({tag, "_repeat"}, {31'd0, bus.repeat_tick}, 32'd0);
        check({tag, "_busy"},   {31'd0, bus.busy},        32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.db_level = 1'b0;
        bus.db_tick  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        hold(1'b0, 3);

        // Single short press: release at E31, short_tick 50 clocks later.
        start_press();
        hold(1'b1, 30);
        check("s1_busy_held", {31'd0, bus.busy}, 32'd1);
        hold(1'b0, 60);
        check("s1_short_cnt", short_cnt - short_base, 1);
        check("s1_short_time", short_last - t0, 81);
        check("s1_long_cnt", long_cnt - long_base, 0);
        check("s1_double_cnt", double_cnt - double_base, 0);
        check("s1_busy_end", {31'd0, bus.busy}, 32'd0);

        // Long press with auto-repeat at 120 and 140, release at E151.
        start_press();
        hold(1'b1, 150);
        hold(1'b0, 80);
        check("s2_long_cnt", long_cnt - long_base, 1);
        check("s2_long_time", long_last - t0, 100);
        check("s2_repeat_cnt", repeat_cnt - repeat_base, 2);
        check("s2_repeat1_time", repeat_prev - t0, 120);
        check("s2_repeat2_time", repeat_last - t0, 140);
        check("s2_short_cnt", short_cnt - short_base, 0);
        check("s2_busy_end", {31'd0, bus.busy}, 32'd0);

        // Double press: second tick 20 clocks after the release, released 10 clocks later.
        start_press();
        hold(1'b1, 30);
        hold(1'b0, 20);
        retick();
        hold(1'b1, 10);
        hold(1'b0, 70);
        check("s3_double_cnt", double_cnt - double_base, 1);
        check("s3_double_time", double_last - t0, 62);
        check("s3_short_cnt", short_cnt - short_base, 0);

        // Second tick on the edge where the gap count reaches 49: double press.
        start_press();
        hold(1'b1, 30);
        hold(1'b0, 50);
        retick();
        hold(1'b1, 5);
        hold(1'b0, 70);
        check("s4a_double_cnt", double_cnt - double_base, 1);
        check("s4a_double_time", double_last - t0, 87);
        check("s4a_short_cnt", short_cnt - short_base, 0);

        // Second tick one clock late: short press, then a separate short press.
        start_press();
        hold(1'b1, 30);
        hold(1'b0, 51);
        retick();
        hold(1'b1, 10);
        hold(1'b0, 70);
        check("s4b_short_cnt", short_cnt - short_base, 2);
        check("s4b_short1_time", short_prev - t0, 81);
        check("s4b_short2_time", short_last - t0, 143);
        check("s4b_double_cnt", double_cnt - double_base, 0);

        // Release on the edge where the hold count reaches 99: no long press.
        start_press();
        hold(1'b1, 99);
        hold(1'b0, 70);
        check("s5_long_cnt", long_cnt - long_base, 0);
        check("s5_short_cnt", short_cnt - short_base, 1);
        check("s5_short_time", short_last - t0, 150);

        // Asynchronous reset in LONG_HELD while repeat_tick is high.
        start_press();
        hold(1'b1, 120);
        @(negedge clk);
        check("s6_repeat_before", {31'd0, bus.repeat_tick}, 32'd1);
        check("s6_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_outputs_zero("s6_async");
        hold(1'b1, 2);
        @(negedge clk);
        reset = 1'b0;
        snap();
        hold(1'b1, 60);
        check("s6_post_ticks", (short_cnt - short_base) + (long_cnt - long_base)
              + (double_cnt - double_base) + (repeat_cnt - repeat_base), 0);
        check("s6_post_busy", {31'd0, bus.busy}, 32'd0);
        hold(1'b0, 60);
        check("s6_release_ticks", (short_cnt - short_base) + (long_cnt - long_base)
              + (double_cnt - double_base) + (repeat_cnt - repeat_base), 0);
        check("s6_release_busy", {31'd0, bus.busy}, 32'd0);

        check("one_hot_ticks", multi_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
